// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line datapath: response classes, frame lengths
// and the CRC7 generator used by both the serializer and the response checker.
package sd_cmd_pkg;

    localparam int SHORT_LEN = 48;
    localparam int LONG_LEN  = 136;
    localparam int SHORT_COV = 40;
    localparam int LONG_COV  = 120;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        RESP_R1 = 2'd0,
        RESP_R2 = 2'd1,
        RESP_R3 = 2'd2
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CRC   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Code 3 is not a distinct class; it behaves like an R1-class response.
    function automatic resp_t resp_decode(input logic [1:0] code);
        case (code)
            2'd1:    return RESP_R2;
            2'd2:    return RESP_R3;
            default: return RESP_R1;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (SD command CRC), MSB first, zero initial value.
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       bit_en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_reg;
    logic       fb;

    assign fb  = bit_in ^ crc_reg[6];
    assign crc = crc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_reg <= '0;
        end else if (clear) begin
            crc_reg <= '0;
        end else if (bit_en) begin
            crc_reg <= {crc_reg[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
        end
    end

endmodule

// File: rtl/cmd_resp_checker.sv
// Checks a deserialized CMD response: serial CRC7 walk over the covered bits, then
// framing/index checks and field extraction with a single done pulse.
module cmd_resp_checker
    import sd_cmd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [135:0] frame,
    input  logic         frame_valid,
    input  logic [1:0]   resp_type,
    input  logic [5:0]   expected_index,
    output logic         busy,
    output logic         done,
    output logic         ok,
    output logic         crc_err,
    output logic         start_err,
    output logic         end_err,
    output logic         index_err,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [127:0] resp_long
);

    state_t         state_reg;
    resp_t          type_reg;
    logic [127:0]   frame_reg;
    logic [1:0]     start_bits_reg;
    logic [5:0]     exp_idx_reg;
    logic [119:0]   walk_reg;
    logic [6:0]     count_reg;
    logic [6:0]     crc;

    resp_t          resp_in;
    logic           capture;
    logic           crc_chk, start_chk, end_chk, idx_chk;
    logic           unused_reserved;

    // Bits 133:128 of an R2 frame are the reserved all-ones field, never inspected.
    assign unused_reserved = &{1'b0, frame[133:128]};

    assign resp_in = resp_decode(resp_type);
    assign capture = (state_reg == ST_IDLE) && frame_valid;

    sd_crc7_serial u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture),
        .bit_en (state_reg == ST_CRC),
        .bit_in (walk_reg[119]),
        .crc    (crc)
    );

    always_comb begin
        start_chk = |start_bits_reg;
        end_chk   = ~frame_reg[0];
        crc_chk   = (type_reg != RESP_R3) && (crc != frame_reg[7:1]);
        idx_chk   = (type_reg == RESP_R1) && (frame_reg[45:40] != exp_idx_reg);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            type_reg       <= RESP_R1;
            frame_reg      <= '0;
            start_bits_reg <= '0;
            exp_idx_reg    <= '0;
            walk_reg       <= '0;
            count_reg      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ok             <= 1'b0;
            crc_err        <= 1'b0;
            start_err      <= 1'b0;
            end_err        <= 1'b0;
            index_err      <= 1'b0;
            resp_index     <= '0;
            resp_arg       <= '0;
            resp_long      <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_valid) begin
                        type_reg    <= resp_in;
                        frame_reg   <= frame[127:0];
                        exp_idx_reg <= expected_index;
                        busy        <= 1'b1;
                        state_reg   <= ST_CRC;
                        if (resp_in == RESP_R2) begin
                            start_bits_reg <= frame[135:134];
                            walk_reg       <= frame[127:8];
                            count_reg      <= 7'(LONG_COV);
                        end else begin
                            start_bits_reg <= frame[47:46];
                            walk_reg       <= {frame[47:8], 80'd0};
                            count_reg      <= 7'(SHORT_COV);
                        end
                    end
                end
                ST_CRC: begin
                    walk_reg  <= {walk_reg[118:0], 1'b0};
                    count_reg <= count_reg - 7'd1;
                    if (count_reg == 7'd1) begin
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    crc_err   <= crc_chk;
                    start_err <= start_chk;
                    end_err   <= end_chk;
                    index_err <= idx_chk;
                    ok        <= ~(crc_chk | start_chk | end_chk | idx_chk);
                    if (type_reg == RESP_R2) begin
                        resp_long <= frame_reg;
                    end else begin
                        resp_index <= frame_reg[45:40];
                        resp_arg   <= frame_reg[39:8];
                    end
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_resp_checker.sv
// Directed bench for cmd_resp_checker: known-good SD response frames and single faults.
module tb_cmd_resp_checker;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [135:0] frame = '0;
    logic         frame_valid = 1'b0;
    logic [1:0]   resp_type = 2'd0;
    logic [5:0]   expected_index = 6'd0;
    logic         busy, done, ok, crc_err, start_err, end_err, index_err;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic [127:0] resp_long;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    localparam logic [135:0] R1_CLEAN = 136'h11_00000900_67;
    localparam logic [135:0] R1_BADCRC = 136'h11_00000A00_67;
    localparam logic [135:0] R1_BADEND = 136'h11_00000900_66;
    localparam logic [135:0] CMD0_PAT = 136'h40_00000000_95;
    localparam logic [135:0] R2_CLEAN = {8'h3F, 120'h0, 8'h01};
    localparam logic [135:0] R3_FRAME = 136'h3F_80FF8000_FF;

    cmd_resp_checker dut (
        .clk            (clk),
        .reset          (reset),
        .frame          (frame),
        .frame_valid    (frame_valid),
        .resp_type      (resp_type),
        .expected_index (expected_index),
        .busy           (busy),
        .done           (done),
        .ok             (ok),
        .crc_err        (crc_err),
        .start_err      (start_err),
        .end_err        (end_err),
        .index_err      (index_err),
        .resp_index     (resp_index),
        .resp_arg       (resp_arg),
        .resp_long      (resp_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Present a frame for one edge, then scramble inputs to prove they were latched.
    task automatic capture(input logic [135:0] f, input logic [1:0] t, input logic [5:0] idx);
        @(negedge clk);
        frame = f;
        resp_type = t;
        expected_index = idx;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        frame = ~f;
        expected_index = ~idx;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run(input logic [135:0] f, input logic [1:0] t, input logic [5:0] idx,
                       output int lat);
        capture(f, t, idx);
        wait_done(lat);
        $display("frame %h type %0d idx %0d -> lat %0d ok %0b crc %0b start %0b end %0b index %0b",
                 f, t, idx, lat, ok, crc_err, start_err, end_err, index_err);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        frame_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, ok, crc_err, start_err, end_err, index_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 0000000",
                     {busy, done, ok, crc_err, start_err, end_err, index_err});
        end
        vectors++;
        if ({resp_index, resp_arg, resp_long} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields got %h %h %h want 0", resp_index, resp_arg, resp_long);
        end
        @(negedge clk);
        frame_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_r1_clean();
        int lat;
        capture(R1_CLEAN, 2'd0, 6'd17);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL r1_busy got %b want 1", busy);
        end
        wait_done(lat);
        $display("frame %h type 0 idx 17 -> lat %0d ok %0b", R1_CLEAN, lat, ok);
        vectors++;
        if (lat !== 41) begin
            miscompares++;
            $display("FAIL r1_latency got %0d want 41", lat);
        end
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err, busy} !== 6'b100000) begin
            miscompares++;
            $display("FAIL r1_flags got %b want 100000",
                     {ok, crc_err, start_err, end_err, index_err, busy});
        end
        vectors++;
        if (resp_index !== 6'd17 || resp_arg !== 32'h00000900) begin
            miscompares++;
            $display("FAIL r1_fields got %h/%h want 11/00000900", resp_index, resp_arg);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || ok !== 1'b1) begin
            miscompares++;
            $display("FAIL r1_pulse_hold got done %b ok %b want 0 1", done, ok);
        end
    endtask

    task automatic test_faults();
        int lat;
        run(R1_BADCRC, 2'd0, 6'd17, lat);
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b01000) begin
            miscompares++;
            $display("FAIL badcrc got %b want 01000", {ok, crc_err, start_err, end_err, index_err});
        end
        run(R1_BADEND, 2'd0, 6'd17, lat);
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b00010) begin
            miscompares++;
            $display("FAIL badend got %b want 00010", {ok, crc_err, start_err, end_err, index_err});
        end
        run(CMD0_PAT, 2'd0, 6'd0, lat);
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b00100) begin
            miscompares++;
            $display("FAIL txbit got %b want 00100", {ok, crc_err, start_err, end_err, index_err});
        end
        run(R1_CLEAN, 2'd3, 6'd18, lat);
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b00001) begin
            miscompares++;
            $display("FAIL badindex got %b want 00001", {ok, crc_err, start_err, end_err, index_err});
        end
    endtask

    task automatic test_r2();
        int lat;
        logic [135:0] f;
        run(R2_CLEAN, 2'd1, 6'd2, lat);
        vectors++;
        if (lat !== 121) begin
            miscompares++;
            $display("FAIL r2_latency got %0d want 121", lat);
        end
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL r2_flags got %b want 10000", {ok, crc_err, start_err, end_err, index_err});
        end
        vectors++;
        if (resp_long !== {120'h0, 8'h01}) begin
            miscompares++;
            $display("FAIL r2_long got %h want %h", resp_long, {120'h0, 8'h01});
        end
        vectors++;
        if (resp_index !== 6'd17 || resp_arg !== 32'h00000900) begin
            miscompares++;
            $display("FAIL r2_short_hold got %h/%h want 11/00000900", resp_index, resp_arg);
        end
        f = R2_CLEAN;
        f[60] = 1'b1;
        run(f, 2'd1, 6'd2, lat);
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b01000) begin
            miscompares++;
            $display("FAIL r2_crc got %b want 01000", {ok, crc_err, start_err, end_err, index_err});
        end
    endtask

    task automatic test_r3();
        int lat;
        logic [127:0] want_long;
        want_long = 128'h1 | (128'h1 << 60);
        run(R3_FRAME, 2'd2, 6'd5, lat);
        vectors++;
        if (lat !== 41) begin
            miscompares++;
            $display("FAIL r3_latency got %0d want 41", lat);
        end
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL r3_flags got %b want 10000", {ok, crc_err, start_err, end_err, index_err});
        end
        vectors++;
        if (resp_arg !== 32'h80FF8000 || resp_index !== 6'h3F) begin
            miscompares++;
            $display("FAIL r3_fields got %h/%h want 3f/80ff8000", resp_index, resp_arg);
        end
        vectors++;
        if (resp_long !== want_long) begin
            miscompares++;
            $display("FAIL r3_long_hold got %h want %h", resp_long, want_long);
        end
    endtask

    task automatic test_ignore_busy();
        int lat, d0;
        capture(R1_CLEAN, 2'd0, 6'd17);
        d0 = done_cnt;
        repeat (9) @(posedge clk);
        @(negedge clk);
        frame = R1_BADCRC;
        resp_type = 2'd1;
        expected_index = 6'd0;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        wait_done(lat);
        $display("frame %h with extra pulse at +10 -> lat %0d ok %0b", R1_CLEAN, lat, ok);
        vectors++;
        if (lat !== 31) begin
            miscompares++;
            $display("FAIL ignore_latency got %0d want 31", lat);
        end
        vectors++;
        if ({ok, crc_err, start_err, end_err, index_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL ignore_flags got %b want 10000", {ok, crc_err, start_err, end_err, index_err});
        end
        repeat (150) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_single_done got %0d dones busy %b want 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        capture(R3_FRAME, 2'd2, 6'd5);
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        $display("reset asserted mid-walk");
        vectors++;
        if ({busy, done, ok, crc_err, start_err, end_err, index_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL abort_flags got %b want 0000000",
                     {busy, done, ok, crc_err, start_err, end_err, index_err});
        end
        vectors++;
        if ({resp_index, resp_arg, resp_long} !== '0) begin
            miscompares++;
            $display("FAIL abort_fields got %h %h %h want 0", resp_index, resp_arg, resp_long);
        end
        @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        repeat (80) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done got %0d dones busy %b want 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, d0;
        d0 = done_cnt;
        run(R1_CLEAN, 2'd0, 6'd17, lat1);
        run(R1_BADCRC, 2'd0, 6'd17, lat2);
        vectors++;
        if (lat1 !== 41 || lat2 !== 41) begin
            miscompares++;
            $display("FAIL b2b_latency got %0d/%0d want 41/41", lat1, lat2);
        end
        vectors++;
        if (crc_err !== 1'b1 || resp_arg !== 32'h00000A00) begin
            miscompares++;
            $display("FAIL b2b_second got crc %b arg %h want 1 00000a00", crc_err, resp_arg);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt - d0 !== 2) begin
            miscompares++;
            $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_r1_clean();
        test_faults();
        test_r2();
        test_r3();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_resp_checker.md
Name: cmd_resp_checker

Overview:
- Downstream stage of the CMD-line deserializer.
- Takes the parallel response frame (136-bit bus plus completion pulse), recomputes CRC7 serially over the covered bits, and checks start, transmission and end bits and the command index.
- Outputs the decoded fields and a one-cycle done pulse with error flags to the command FSM.

Parameters:
SHORT_LEN, 48, bit length of R1/R1b/R3/R6/R7 frames
LONG_LEN, 136, bit length of R2 frames

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
frame  in  136  deserialized response; first-received bit is frame[len-1]; short frames occupy frame[47:0]
frame_valid  in  1  one-cycle pulse, frame stable on this cycle (driven from deserializer complete)
resp_type  in  2  0=R1-class 48b with CRC, 1=R2 136b, 2=R3 48b no CRC, 3=treated as 0
expected_index  in  6  index of the command just sent
busy  out  1  check in progress; frame_valid ignored while high
done  out  1  one-cycle pulse, results valid
ok  out  1  no error flag set (valid with done, held after)
crc_err  out  1  CRC7 mismatch
start_err  out  1  start or transmission bit not 0
end_err  out  1  end bit not 1
index_err  out  1  received index != expected_index (R1-class only)
resp_index  out  6  frame[45:40] of short frame
resp_arg  out  32  frame[39:8] of short frame
resp_long  out  128  frame[127:0] of R2 frame (CID/CSD incl. CRC and end bit)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, every output 0, internal shift register, counter and CRC all 0.
- FSM states IDLE, CRC, CHECK.
- IDLE, frame_valid=1 at edge E0:
  - Latch frame and resp_type.
  - Load the walk register with the covered bits, MSB first:
    - short: frame[47:8], 40 bits
    - R2: frame[127:8], 120 bits
  - Counter = 40 or 120; crc = 0; busy=1; go to CRC.
- CRC, one bit per edge:
  - fb = bit ^ crc[6]
  - crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb} (poly x^7+x^3+1, init 0)
  - Counter decrements; at 0, go to CHECK.
- Timing: CRC edges are E1..EN (N=40 or 120). CHECK at edge EN+1:
  - Register all flags and fields; done=1 for exactly one cycle; busy=0; return to IDLE.
  - Latency from capture edge to done: 41 cycles (short), 121 cycles (R2). R3 walks 40 bits for uniform latency.
- Checks, short frames:
  - start_err = frame[47] | frame[46]
  - end_err = ~frame[0]
  - crc_err = (crc != frame[7:1]), forced 0 for R3
  - index_err = (frame[45:40] != expected_index), R1-class only, 0 for R3
- Checks, R2:
  - start_err = frame[135] | frame[134]
  - end_err = ~frame[0]
  - crc_err = (crc != frame[7:1])
  - index_err = 0; the reserved 111111 field is not checked.
- ok = ~(crc_err|start_err|end_err|index_err).
- Output fields:
  - resp_index/resp_arg update only for short types; resp_long only for R2.
  - All outputs hold until the next done.
- frame_valid while busy (including the CHECK edge): ignored, no side effect.
- frame_valid on the cycle after done: accepted normally (back-to-back).
- expected_index is sampled at E0, not at CHECK.
- Reset asserted mid-walk: immediate abort to IDLE, outputs 0, no done pulse.

Decomposition:
- Shared package sd_cmd_pkg:
  - resp_type encodings (RESP_R1, RESP_R2, RESP_R3)
  - CRC7 polynomial constant
  - SHORT_LEN/LONG_LEN and covered-bit counts (40, 120)
- One sub-module, sd_crc7_serial: clear, bit_en, bit_in, crc[6:0]. It is reused later by the command serializer.

Test Plan:
- R1 clean: frame=48'h11_00000900_67, type 0, expected_index=17 -> done 41 cycles after capture, ok=1, resp_index=17, resp_arg=32'h00000900, all errors 0.
- CRC/end/index faults: frame=48'h11_00000A00_67 -> crc_err=1, ok=0. frame=48'h11_00000900_66 -> end_err=1, crc_err=0. Clean frame with expected_index=18 -> index_err=1 only.
- Transmission-bit fault with valid CRC: frame=48'h40_00000000_95 (CMD0 pattern), expected_index=0 -> crc_err=0, start_err=1.
- R2: frame={8'h3F, 120'h0, 8'h01}, type 1 -> done 121 cycles after capture, ok=1, resp_long={120'h0, 8'h01}. Set frame[60]=1 -> crc_err=1.
- R3: frame=48'h3F_80FF8000_FF, type 2 -> ok=1, resp_arg=32'h80FF8000, crc_err=0, index_err=0.
- Control: second frame_valid pulse 10 cycles after capture -> ignored, single done. Reset=0 at capture+20 -> busy=0 and all outputs 0 immediately, no done. Back-to-back frame_valid on the cycle after done -> accepted.
